jtag_tap_port: RTL and testbench
================================

Name: jtag_tap_port

Overview:
- Oversampled IEEE 1149.1 TAP controller for the FPGA dev chassis. It sits between the raw JTAG GPIO pins (TCK/TMS/TDI/TDO) and the processor's debug logic.
- It samples the slow, asynchronous JTAG pins in the processor clock domain and runs the 16-state TAP machine.
- It exposes a parallel IR value and a parallel DR capture/update handshake to the core, plus a 4-bit state code for the hex debug displays.

Parameters:
- IR_W, 4, instruction register width.
- DR_W, 16, data register width (non-BYPASS instructions).
- IR_RESET, 4'h1, IR value loaded in Test-Logic-Reset.
- SYNC_STAGES, 2, synchronizer flops per JTAG input (min 2).

Ports:
- tap_clk  in  1  system clock (processor clock).
- tap_rst  in  1  synchronous active-high reset.
- tap_tck_i  in  1  raw JTAG TCK pin.
- tap_tms_i  in  1  raw JTAG TMS pin.
- tap_tdi_i  in  1  raw JTAG TDI pin.
- tap_tdo_o  out  1  JTAG TDO data.
- tap_tdoEn_o  out  1  TDO drive enable; pin tristated when 0.
- tap_drIn_i  in  DR_W  parallel value captured in Capture-DR.
- tap_drOut_o  out  DR_W  parallel value latched at Update-DR.
- tap_drUpdate_o  out  1  one-cycle pulse when tap_drOut_o is updated.
- tap_irValue_o  out  IR_W  current instruction.
- tap_irUpdate_o  out  1  one-cycle pulse when tap_irValue_o is updated.
- tap_state_o  out  4  TAP state code for debug display.

Behaviour:
- Clock and reset: one clock, tap_clk. Reset tap_rst is synchronous and active-high.
- Input synchronization: TCK, TMS and TDI each pass through SYNC_STAGES flops.
- Edge detection: compare synced TCK against a previous-value register. Rising edge (rise) = prev 0, now 1; falling edge (fall) = prev 1, now 0.
- TCK timing requirement: TCK high and low times must each be at least SYNC_STAGES+1 tap_clk cycles. Faster TCK is unsupported and not detected.
- Actions on rise, evaluated against the current state (S) using synced TMS/TDI; all take effect on the same tap_clk edge:
  - Next state per the 1149.1 graph.
  - Capture-DR: DR shift reg <= tap_drIn_i, or 1'b0 if the instruction is BYPASS (IR all ones).
  - Capture-IR: IR shift reg <= {0...0,1} (LSB = 1, rest 0).
  - Shift-DR / Shift-IR: shift reg <= {TDI, reg[W-1:1]} (LSB first). In BYPASS, the DR path is a single bit.
  - Update-DR (entered from Exit1/Exit2): tap_drOut_o <= DR shift reg and tap_drUpdate_o = 1 for exactly one cycle, the cycle after the rise. Suppressed in BYPASS.
  - Update-IR: tap_irValue_o <= IR shift reg and tap_irUpdate_o pulses for one cycle.
  - Entering Test-Logic-Reset: tap_irValue_o <= IR_RESET, with no irUpdate pulse.
- Actions on fall:
  - tap_tdo_o <= LSB of the active shift reg.
  - tap_tdoEn_o <= 1 iff S is Shift-DR or Shift-IR; otherwise tap_tdo_o <= 0 and tap_tdoEn_o <= 0.
- State encoding (tap_state_o):
  - TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8.
  - SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PauIR=D, Ex2IR=E, UpdIR=F.
- Latency: state changes 1 tap_clk after the synced rise is seen, i.e. SYNC_STAGES+1 cycles after the pin edge.
- Reset values (tap_rst, any time including mid-scan):
  - state = TLR; tap_irValue_o = IR_RESET.
  - tap_drOut_o = 0; shift regs = 0.
  - tap_tdo_o = 0; tap_tdoEn_o = 0; both update pulses = 0.
  - Synchronizers and the TCK previous-value register = 0.
  - No update pulse is issued for an aborted scan.
- Boundary conditions:
  - Five consecutive rises with TMS=1 reach TLR from any state. Intermediate Update states still pulse.
  - rise and fall can never coincide; only one edge is seen per cycle.
  - tap_drIn_i is sampled only at the Capture-DR rise; changes at other times are ignored.
  - tap_drOut_o holds between updates.

Test Plan:
- Reset: pulse tap_rst with TCK toggling -> tap_state_o=0, tap_irValue_o=4'h1, tap_tdoEn_o=0, no update pulses.
- IR scan: from TLR, TMS 0,1,1,0,0 -> ShIR (B). Then shift TDI 1,0,1,0 LSB-first (TMS=1 on the last bit), then TMS 1,0 -> TDO bits 1,0,0,0; one tap_irUpdate_o pulse; tap_irValue_o=4'h5; state RTI (1).
- DR scan: tap_drIn_i=16'hA5C3, IR=4'h5, shift TDI=16'h1234 LSB-first -> TDO reads 16'hA5C3 LSB-first; tap_drOut_o=16'h1234; exactly one tap_drUpdate_o pulse.
- BYPASS: load IR=4'hF, shift DR with TDI 1,0,1,1 -> TDO 0,1,0,1 (one-bit delay); tap_drUpdate_o never asserts; tap_drOut_o unchanged.
- TMS reset: from PauDR, five rises with TMS=1 -> passes Ex2DR, UpdDR (one drUpdate pulse), SelDR, SelIR, TLR; tap_irValue_o back to 4'h1.
- Reset mid-scan: assert tap_rst after 7 bits of a ShDR scan -> next cycle state=0, tap_tdoEn_o=0, tap_drOut_o=0, no drUpdate pulse; a following clean scan works normally.

Source files
------------

// File: rtl/jtag_tap_port_if.sv
// JTAG TAP port bundle: raw JTAG pins plus the parallel IR/DR core handshake.
//   master : pin/core side (drives TCK/TMS/TDI and the DR capture value)
//   slave  : the TAP controller (drives TDO, DR/IR parallel outputs, state code)
interface jtag_tap_port_if #(
  parameter int unsigned IR_W = 4,
  parameter int unsigned DR_W = 16
);
  logic            tap_tck_i;
  logic            tap_tms_i;
  logic            tap_tdi_i;
  logic            tap_tdo_o;
  logic            tap_tdoEn_o;
  logic [DR_W-1:0] tap_drIn_i;
  logic [DR_W-1:0] tap_drOut_o;
  logic            tap_drUpdate_o;
  logic [IR_W-1:0] tap_irValue_o;
  logic            tap_irUpdate_o;
  logic [3:0]      tap_state_o;

  modport master (
    output tap_tck_i, tap_tms_i, tap_tdi_i, tap_drIn_i,
    input  tap_tdo_o, tap_tdoEn_o, tap_drOut_o, tap_drUpdate_o,
           tap_irValue_o, tap_irUpdate_o, tap_state_o
  );

  modport slave (
    input  tap_tck_i, tap_tms_i, tap_tdi_i, tap_drIn_i,
    output tap_tdo_o, tap_tdoEn_o, tap_drOut_o, tap_drUpdate_o,
           tap_irValue_o, tap_irUpdate_o, tap_state_o
  );
endinterface

// File: rtl/jtag_tap_port.sv
// Oversampled IEEE 1149.1 TAP controller. The asynchronous JTAG pins are
// synchronized into tap_clk, TCK edges are detected from the synced copy and
// the 16-state TAP machine advances on each detected TCK rise.
// Ports:
//   tap_clk  : processor clock
//   tap_rst  : synchronous active-high reset
//   bus      : jtag_tap_port_if.slave (pins TCK/TMS/TDI/TDO/TDO-enable,
//              parallel DR in/out + update pulse, IR value + update pulse,
//              4-bit TAP state code)
module jtag_tap_port #(
  parameter int unsigned     IR_W        = 4,
  parameter int unsigned     DR_W        = 16,
  parameter logic [IR_W-1:0] IR_RESET    = IR_W'(1),
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic            tap_clk,
  input  logic            tap_rst,
  jtag_tap_port_if.slave  bus
);

  // Fewer than two stages is not a safe synchronizer; clamp rather than fail.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
    UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
  } tap_state_e;

  logic [SYNC_N-1:0] tck_sync;
  logic [SYNC_N-1:0] tms_sync;
  logic [SYNC_N-1:0] tdi_sync;
  logic              tck_prev;

  tap_state_e        state;
  logic [IR_W-1:0]   ir_shift;
  logic [DR_W-1:0]   dr_shift;
  logic [IR_W-1:0]   ir_value;
  logic [DR_W-1:0]   dr_out;
  logic              dr_update;
  logic              ir_update;
  logic              tdo;
  logic              tdo_en;

  logic              tck_s;
  logic              tms_s;
  logic              tdi_s;
  logic              rise;
  logic              fall;
  logic              bypass;
  tap_state_e        nxt;

  // 1149.1 state graph.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    unique case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  assign tck_s  = tck_sync[SYNC_N-1];
  assign tms_s  = tms_sync[SYNC_N-1];
  assign tdi_s  = tdi_sync[SYNC_N-1];
  assign rise   = tck_s & ~tck_prev;
  assign fall   = ~tck_s & tck_prev;
  assign bypass = &ir_value;
  assign nxt    = tap_next(state, tms_s);

  // Synchronizers, edge detect, TAP machine and all registered outputs.
  always_ff @(posedge tap_clk) begin
    if (tap_rst) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      tck_prev  <= 1'b0;
      state     <= TLR;
      ir_shift  <= '0;
      dr_shift  <= '0;
      ir_value  <= IR_RESET;
      dr_out    <= '0;
      dr_update <= 1'b0;
      ir_update <= 1'b0;
      tdo       <= 1'b0;
      tdo_en    <= 1'b0;
    end else begin
      tck_sync  <= {tck_sync[SYNC_N-2:0], bus.tap_tck_i};
      tms_sync  <= {tms_sync[SYNC_N-2:0], bus.tap_tms_i};
      tdi_sync  <= {tdi_sync[SYNC_N-2:0], bus.tap_tdi_i};
      tck_prev  <= tck_s;
      dr_update <= 1'b0;
      ir_update <= 1'b0;

      if (rise) begin
        state <= nxt;

        // Capture/shift act on the state being left at this rise.
        unique case (state)
          CAP_DR: dr_shift <= bypass ? '0 : bus.tap_drIn_i;
          SH_DR: begin
            // BYPASS uses only bit 0 as a one-bit register.
            if (bypass) dr_shift[0] <= tdi_s;
            else        dr_shift    <= {tdi_s, dr_shift[DR_W-1:1]};
          end
          CAP_IR: ir_shift <= IR_W'(1);
          SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_W-1:1]};
          default: ;
        endcase

        // Updates act on the state being entered.
        if (nxt == UPD_DR && !bypass) begin
          dr_out    <= dr_shift;
          dr_update <= 1'b1;
        end
        if (nxt == UPD_IR) begin
          ir_value  <= ir_shift;
          ir_update <= 1'b1;
        end
        if (nxt == TLR) begin
          ir_value <= IR_RESET;
        end
      end else if (fall) begin
        unique case (state)
          SH_DR: begin
            tdo    <= dr_shift[0];
            tdo_en <= 1'b1;
          end
          SH_IR: begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
          end
          default: begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tap_tdo_o      = tdo;
  assign bus.tap_tdoEn_o    = tdo_en;
  assign bus.tap_drOut_o    = dr_out;
  assign bus.tap_drUpdate_o = dr_update;
  assign bus.tap_irValue_o  = ir_value;
  assign bus.tap_irUpdate_o = ir_update;
  assign bus.tap_state_o    = state;

endmodule

// File: tb/tb_jtag_tap_port.sv
// Directed bench for jtag_tap_port: expected TDO bits and expected update
// values go into queues as stimulus is driven and are popped when the DUT
// produces the corresponding output.
module tb_jtag_tap_port;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;
  int dr_pulses = 0;
  int ir_pulses = 0;

  logic        tdo_q[$];
  logic [15:0] dr_q[$];
  logic [3:0]  ir_q[$];

  jtag_tap_port_if bus ();

  jtag_tap_port dut (
    .tap_clk (clk),
    .tap_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Update pulses: every high cycle must match a queued expectation.
  always @(negedge clk) begin
    if (bus.tap_drUpdate_o === 1'b1) begin
      dr_pulses++;
      if (dr_q.size() == 0) check("dr_unexpected_pulse", 32'(dr_q.size()), 32'd1);
      else                  check("dr_out_at_update", 32'(bus.tap_drOut_o), 32'(dr_q.pop_front()));
    end
    if (bus.tap_irUpdate_o === 1'b1) begin
      ir_pulses++;
      if (ir_q.size() == 0) check("ir_unexpected_pulse", 32'(ir_q.size()), 32'd1);
      else                  check("ir_value_at_update", 32'(bus.tap_irValue_o), 32'(ir_q.pop_front()));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One TCK period (6 clk low setup incl. prior low phase, 6 high, 6 low).
  // TDO/enable sampled just before the rise.
  task automatic tick(input logic tms, input logic tdi, output logic tdo, output logic en);
    @(negedge clk);
    bus.tap_tms_i = tms;
    bus.tap_tdi_i = tdi;
    repeat (3) @(negedge clk);
    tdo = bus.tap_tdo_o;
    en  = bus.tap_tdoEn_o;
    bus.tap_tck_i = 1'b1;
    repeat (6) @(negedge clk);
    bus.tap_tck_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int n);
    logic a, b;
    for (int i = 0; i < n; i++) tick(bits[i], 1'b0, a, b);
  endtask

  task automatic shift_bits(input logic [15:0] tdi, input logic [15:0] exp_tdo,
                            input int n, input bit do_exit, input string tag);
    logic seen, en;
    for (int i = 0; i < n; i++) begin
      tdo_q.push_back(exp_tdo[i]);
      tick(do_exit && (i == n - 1), tdi[i], seen, en);
      check({tag, "_tdo_en"}, 32'(en), 32'd1);
      check({tag, "_tdo"}, 32'(seen), 32'(tdo_q.pop_front()));
    end
  endtask

  // From RTI: load an instruction, end in RTI.
  task automatic shift_ir(input logic [3:0] value);
    tms_seq(8'b0000_0011, 4);
    check("ir_at_shift_ir", 32'(bus.tap_state_o), 32'hB);
    shift_bits(16'(value), 16'h0001, 4, 1'b1, "ir_scan");
    ir_q.push_back(value);
    tms_seq(8'b0000_0001, 2);
    check("ir_back_rti", 32'(bus.tap_state_o), 32'h1);
    check("ir_value", 32'(bus.tap_irValue_o), 32'(value));
    check("ir_tdo_en_off", 32'(bus.tap_tdoEn_o), 32'd0);
  endtask

  // From RTI: full DR scan of n bits, end in RTI.
  task automatic scan_dr(input logic [15:0] din, input logic [15:0] tdi,
                         input logic [15:0] exp_tdo, input int n, input bit upd);
    bus.tap_drIn_i = din;
    tms_seq(8'b0000_0001, 3);
    bus.tap_drIn_i = 16'($urandom);
    check("dr_at_shift_dr", 32'(bus.tap_state_o), 32'h4);
    shift_bits(tdi, exp_tdo, n, 1'b1, "dr_scan");
    if (upd) dr_q.push_back(tdi);
    tms_seq(8'b0000_0001, 2);
    check("dr_back_rti", 32'(bus.tap_state_o), 32'h1);
  endtask

  initial begin
    int dp, ip;
    logic [3:0] exp_st [5] = '{4'h7, 4'h8, 4'h2, 4'h9, 4'h0};
    logic a, b;

    // Reset with TCK toggling.
    rst = 1'b1;
    bus.tap_tck_i  = 1'b0;
    bus.tap_tms_i  = 1'b1;
    bus.tap_tdi_i  = 1'b0;
    bus.tap_drIn_i = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.tap_tck_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.tap_tck_i = 1'b0;
      repeat (3) @(negedge clk);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_state", 32'(bus.tap_state_o), 32'h0);
    check("rst_ir", 32'(bus.tap_irValue_o), 32'h1);
    check("rst_tdo_en", 32'(bus.tap_tdoEn_o), 32'd0);
    check("rst_tdo", 32'(bus.tap_tdo_o), 32'd0);
    check("rst_dr_out", 32'(bus.tap_drOut_o), 32'h0);
    check("rst_no_pulses", 32'(dr_pulses + ir_pulses), 32'd0);

    // Latency: state moves SYNC_STAGES+1 cycles after the pin edge.
    bus.tap_tms_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.tap_tck_i = 1'b1;
    repeat (2) @(negedge clk);
    check("latency_before", 32'(bus.tap_state_o), 32'h0);
    @(negedge clk);
    check("latency_after", 32'(bus.tap_state_o), 32'h1);
    repeat (4) @(negedge clk);
    bus.tap_tck_i = 1'b0;
    repeat (6) @(negedge clk);

    // IR scan: load 4'h5.
    shift_ir(4'h5);
    check("ir_pulse_count", 32'(ir_pulses), 32'd1);

    // DR scan: capture A5C3, shift in 1234.
    scan_dr(16'hA5C3, 16'h1234, 16'hA5C3, 16, 1'b1);
    check("dr_out_1234", 32'(bus.tap_drOut_o), 32'h1234);
    check("dr_pulse_count", 32'(dr_pulses), 32'd1);

    // BYPASS: one-bit delay, no update.
    shift_ir(4'hF);
    dp = dr_pulses;
    scan_dr(16'hFFFF, 16'h000D, 16'h000A, 4, 1'b0);
    check("bypass_no_pulse", 32'(dr_pulses), 32'(dp));
    check("bypass_dr_out_held", 32'(bus.tap_drOut_o), 32'h1234);

    // TMS reset from Pause-DR.
    shift_ir(4'h5);
    bus.tap_drIn_i = 16'h1111;
    tms_seq(8'b0000_0001, 3);
    shift_bits(16'hBEEF, 16'h1111, 16, 1'b1, "pause_scan");
    tms_seq(8'b0000_0000, 1);
    check("at_pause_dr", 32'(bus.tap_state_o), 32'h6);
    dr_q.push_back(16'hBEEF);
    dp = dr_pulses;
    ip = ir_pulses;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, a, b);
      check("tms_reset_walk", 32'(bus.tap_state_o), 32'(exp_st[i]));
    end
    check("tms_reset_ir", 32'(bus.tap_irValue_o), 32'h1);
    check("tms_reset_dr_pulse", 32'(dr_pulses), 32'(dp + 1));
    check("tms_reset_no_ir_pulse", 32'(ir_pulses), 32'(ip));
    check("tms_reset_dr_out", 32'(bus.tap_drOut_o), 32'hBEEF);

    // Reset mid-scan after 7 bits.
    tms_seq(8'b0000_0000, 1);
    bus.tap_drIn_i = 16'h9876;
    tms_seq(8'b0000_0001, 3);
    shift_bits(16'h0055, 16'h9876, 7, 1'b0, "abort_scan");
    check("abort_in_shift", 32'(bus.tap_state_o), 32'h4);
    dp = dr_pulses;
    @(negedge clk);
    bus.tap_tms_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(bus.tap_state_o), 32'h0);
    check("abort_tdo_en", 32'(bus.tap_tdoEn_o), 32'd0);
    check("abort_dr_out", 32'(bus.tap_drOut_o), 32'h0);
    check("abort_ir", 32'(bus.tap_irValue_o), 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_pulse", 32'(dr_pulses), 32'(dp));

    // Clean scan after the abort.
    tms_seq(8'b0000_0000, 1);
    scan_dr(16'h3C5A, 16'h0F0F, 16'h3C5A, 16, 1'b1);
    check("post_abort_dr_out", 32'(bus.tap_drOut_o), 32'h0F0F);
    check("post_abort_pulse", 32'(dr_pulses), 32'(dp + 1));

    repeat (4) @(negedge clk);
    check("dr_q_drained", 32'(dr_q.size()), 32'd0);
    check("ir_q_drained", 32'(ir_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
